// File: rtl/mem_axi_bridge.sv
// Single-outstanding AXI4-Lite master for the core's data memory port.
// Ports: core request/response (mem_*), stall/error to ctrl, AXI4-Lite AW/W/B/AR/R.
module mem_axi_bridge #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd_en_i,
    input  logic              mem_wr_en_i,
    input  logic [ADDR_W-1:0] addr_mem_rd_i,
    input  logic [ADDR_W-1:0] addr_mem_wr_i,
    input  logic [DATA_W-1:0] data_mem_wr_i,
    input  logic [STRB_W-1:0] strb_mem_wr_i,
    output logic [DATA_W-1:0] data_mem_o,
    output logic              stall_mem_o,
    output logic              bus_err_o,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [STRB_W-1:0] wstrb_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    input  logic [1:0]        bresp_i,
    input  logic              bvalid_i,
    output logic              bready_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rvalid_i,
    output logic              rready_o
);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE
    } state_t;

    state_t state_q, state_d;

    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              rd_pend_q, rd_pend_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // channel still waiting after this cycle's handshake
    logic aw_left, w_left;
    assign aw_left = awvalid_q & ~awready_i;
    assign w_left  = wvalid_q & ~wready_i;

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        rd_pend_d = rd_pend_q;
        err_d     = err_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (mem_wr_en_i) begin
                    awaddr_d  = addr_mem_wr_i;
                    wdata_d   = data_mem_wr_i;
                    wstrb_d   = strb_mem_wr_i;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    rd_pend_d = mem_rd_en_i;
                    if (mem_rd_en_i)
                        araddr_d = addr_mem_rd_i;
                    state_d = WR_REQ;
                end else if (mem_rd_en_i) begin
                    araddr_d  = addr_mem_rd_i;
                    arvalid_d = 1'b1;
                    rd_pend_d = 1'b0;
                    state_d   = RD_REQ;
                end
            end
            WR_REQ: begin
                awvalid_d = aw_left;
                wvalid_d  = w_left;
                if (!aw_left && !w_left) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid_i) begin
                    bready_d = 1'b0;
                    if (bresp_i != 2'b00)
                        err_d = 1'b1;
                    if (rd_pend_q) begin
                        rd_pend_d = 1'b0;
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RD_REQ: begin
                if (arready_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (rvalid_i) begin
                    rready_d = 1'b0;
                    rdata_d  = rdata_i;
                    if (rresp_i != 2'b00)
                        err_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // held request is the one just served; drop back to IDLE
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            err_q     <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            rd_pend_q <= rd_pend_d;
            err_q     <= err_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
        end
    end

    assign awvalid_o   = awvalid_q;
    assign wvalid_o    = wvalid_q;
    assign bready_o    = bready_q;
    assign arvalid_o   = arvalid_q;
    assign rready_o    = rready_q;
    assign awaddr_o    = awaddr_q;
    assign araddr_o    = araddr_q;
    assign wdata_o     = wdata_q;
    assign wstrb_o     = wstrb_q;
    assign data_mem_o  = rdata_q;
    assign bus_err_o   = err_q & (state_q == DONE);
    assign stall_mem_o = (mem_rd_en_i | mem_wr_en_i) & (state_q != DONE);

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Directed bench for mem_axi_bridge with a small AXI4-Lite slave model.
// Expected values are hand-computed constants per scenario.
module tb_mem_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd_en, mem_wr_en;
    logic [63:0] addr_rd, addr_wr, wr_data;
    logic [7:0]  wr_strb;
    logic [63:0] data_mem;
    logic        stall, bus_err;
    logic [63:0] awaddr, wdata, araddr, rdata;
    logic [7:0]  wstrb;
    logic        awvalid, awready, wvalid, wready;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;

    // slave configuration
    int          aw_wait, w_wait;
    logic [63:0] rdata_val;
    logic [1:0]  rresp_val, bresp_val;

    // slave bookkeeping
    int          aw_cnt, w_cnt, cyc_n;
    int          n_aw, n_w, n_b, n_ar, n_r;
    int          aw_hi, w_hi, b_cyc, ar_cyc;
    logic        aw_got, w_got;
    logic [63:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [7:0]  cap_wstrb;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_axi_bridge dut (
        .clk(clk), .rst(rst),
        .mem_rd_en_i(mem_rd_en), .mem_wr_en_i(mem_wr_en),
        .addr_mem_rd_i(addr_rd), .addr_mem_wr_i(addr_wr),
        .data_mem_wr_i(wr_data), .strb_mem_wr_i(wr_strb),
        .data_mem_o(data_mem), .stall_mem_o(stall), .bus_err_o(bus_err),
        .awaddr_o(awaddr), .awvalid_o(awvalid), .awready_i(awready),
        .wdata_o(wdata), .wstrb_o(wstrb), .wvalid_o(wvalid), .wready_i(wready),
        .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready),
        .araddr_o(araddr), .arvalid_o(arvalid), .arready_i(arready),
        .rdata_i(rdata), .rresp_i(rresp), .rvalid_i(rvalid), .rready_o(rready)
    );

    assign awready = (aw_cnt >= aw_wait);
    assign wready  = (w_cnt >= w_wait);
    assign arready = 1'b1;
    assign bresp   = bresp_val;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; cyc_n <= 0;
            n_aw <= 0; n_w <= 0; n_b <= 0; n_ar <= 0; n_r <= 0;
            aw_hi <= 0; w_hi <= 0; b_cyc <= 0; ar_cyc <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
            bvalid <= 1'b0; rvalid <= 1'b0;
            rdata <= '0; rresp <= '0;
            cap_awaddr <= '0; cap_wdata <= '0;
            cap_araddr <= '0; cap_wstrb <= '0;
        end else begin
            cyc_n <= cyc_n + 1;
            if (awvalid) aw_hi <= aw_hi + 1;
            if (wvalid) w_hi <= w_hi + 1;
            if (awvalid && awready) begin
                aw_cnt <= 0; n_aw <= n_aw + 1;
                cap_awaddr <= awaddr; aw_got <= 1'b1;
            end else if (awvalid) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (wvalid && wready) begin
                w_cnt <= 0; n_w <= n_w + 1;
                cap_wdata <= wdata; cap_wstrb <= wstrb; w_got <= 1'b1;
            end else if (wvalid) begin
                w_cnt <= w_cnt + 1;
            end
            if ((aw_got || (awvalid && awready)) &&
                (w_got || (wvalid && wready))) begin
                bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0; n_b <= n_b + 1; b_cyc <= cyc_n;
            end
            if (arvalid && arready) begin
                rvalid <= 1'b1; rdata <= rdata_val; rresp <= rresp_val;
                n_ar <= n_ar + 1; cap_araddr <= araddr; ar_cyc <= cyc_n;
            end
            if (rvalid && rready) begin
                rvalid <= 1'b0; n_r <= n_r + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue a request, count stall cycles, return positioned in DONE.
    task automatic do_req(input logic rd, input logic wr,
                          input logic [63:0] ra, input logic [63:0] wa,
                          input logic [63:0] wd, input logic [7:0] st,
                          input bit keep, output int cyc);
        @(negedge clk);
        mem_rd_en = rd; mem_wr_en = wr;
        addr_rd = ra; addr_wr = wa; wr_data = wd; wr_strb = st;
        #1;
        cyc = 0;
        while (stall && cyc < 50) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        if (!keep) begin
            mem_rd_en = 1'b0; mem_wr_en = 1'b0;
        end
    endtask

    int c, b_ar, b_aw, b_w, b_b, b_awhi, b_whi;

    initial begin
        rst = 1'b1;
        mem_rd_en = 0; mem_wr_en = 0;
        addr_rd = '0; addr_wr = '0; wr_data = '0; wr_strb = '0;
        aw_wait = 0; w_wait = 0;
        rdata_val = '0; rresp_val = 2'b00; bresp_val = 2'b00;
        #12;
        check("rst_awvalid", 64'(awvalid), 64'd0);
        check("rst_wvalid", 64'(wvalid), 64'd0);
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_bready", 64'(bready), 64'd0);
        check("rst_rready", 64'(rready), 64'd0);
        check("rst_data", data_mem, 64'd0);
        check("rst_err", 64'(bus_err), 64'd0);
        check("rst_awaddr", awaddr, 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // single read, zero-wait
        rdata_val = 64'h1122_3344_5566_7788;
        b_ar = n_ar;
        do_req(1, 0, 64'h8000_0010, 0, 0, 0, 0, c);
        check("rd_stall", 64'(c), 64'd3);
        check("rd_data", data_mem, 64'h1122_3344_5566_7788);
        check("rd_err", 64'(bus_err), 64'd0);
        check("rd_araddr", cap_araddr, 64'h8000_0010);
        check("rd_n_ar", 64'(n_ar - b_ar), 64'd1);

        // write with awready delayed 2 cycles
        aw_wait = 2;
        b_aw = n_aw; b_w = n_w; b_b = n_b; b_ar = n_ar;
        b_awhi = aw_hi; b_whi = w_hi;
        do_req(0, 1, 0, 64'h8000_0008, 64'hDEAD_BEEF, 8'h0F, 0, c);
        check("wr_stall", 64'(c), 64'd5);
        check("wr_aw_hi", 64'(aw_hi - b_awhi), 64'd3);
        check("wr_w_hi", 64'(w_hi - b_whi), 64'd1);
        check("wr_n_b", 64'(n_b - b_b), 64'd1);
        check("wr_n_aw", 64'(n_aw - b_aw), 64'd1);
        check("wr_n_ar", 64'(n_ar - b_ar), 64'd0);
        check("wr_awaddr", cap_awaddr, 64'h8000_0008);
        check("wr_wdata", cap_wdata, 64'hDEAD_BEEF);
        check("wr_wstrb", 64'(cap_wstrb), 64'h0F);
        check("wr_data_keep", data_mem, 64'h1122_3344_5566_7788);
        aw_wait = 0;

        // combined write + read
        rdata_val = 64'hCAFE_F00D_1234_5678;
        b_aw = n_aw; b_w = n_w; b_b = n_b; b_ar = n_ar;
        do_req(1, 1, 64'h8000_0028, 64'h8000_0020,
               64'h0123_4567_89AB_CDEF, 8'hFF, 0, c);
        check("wr_rd_stall", 64'(c), 64'd5);
        check("wr_rd_n_aw", 64'(n_aw - b_aw), 64'd1);
        check("wr_rd_n_w", 64'(n_w - b_w), 64'd1);
        check("wr_rd_n_b", 64'(n_b - b_b), 64'd1);
        check("wr_rd_n_ar", 64'(n_ar - b_ar), 64'd1);
        check("wr_rd_order", 64'(ar_cyc > b_cyc), 64'd1);
        check("wr_rd_araddr", cap_araddr, 64'h8000_0028);
        check("wr_rd_data", data_mem, 64'hCAFE_F00D_1234_5678);

        // error read then OKAY read
        rdata_val = 64'hA5A5_A5A5_5A5A_5A5A; rresp_val = 2'b10;
        do_req(1, 0, 64'h8000_0030, 0, 0, 0, 0, c);
        check("err_pulse", 64'(bus_err), 64'd1);
        check("err_data", data_mem, 64'hA5A5_A5A5_5A5A_5A5A);
        @(negedge clk); #1;
        check("err_clear", 64'(bus_err), 64'd0);
        rdata_val = 64'h0000_0000_0000_0042; rresp_val = 2'b00;
        do_req(1, 0, 64'h8000_0038, 0, 0, 0, 0, c);
        check("ok_err", 64'(bus_err), 64'd0);
        check("ok_data", data_mem, 64'h42);

        // request held through DONE, then new read
        b_ar = n_ar;
        rdata_val = 64'h1111;
        do_req(1, 0, 64'h8000_0040, 0, 0, 0, 1, c);
        check("hold_n_ar1", 64'(n_ar - b_ar), 64'd1);
        rdata_val = 64'h2222;
        do_req(1, 0, 64'h8000_0048, 0, 0, 0, 0, c);
        check("hold_stall2", 64'(c), 64'd3);
        check("hold_n_ar2", 64'(n_ar - b_ar), 64'd2);
        check("hold_araddr", cap_araddr, 64'h8000_0048);
        check("hold_data", data_mem, 64'h2222);

        // reset while in RD_RESP
        rdata_val = 64'h3333;
        @(negedge clk);
        mem_rd_en = 1'b1; addr_rd = 64'h8000_0050;
        @(negedge clk);
        @(negedge clk); #1;
        check("rr_rready", 64'(rready), 64'd1);
        rst = 1'b1;
        #1;
        check("rr_rready0", 64'(rready), 64'd0);
        check("rr_arvalid0", 64'(arvalid), 64'd0);
        check("rr_data0", data_mem, 64'd0);
        mem_rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rdata_val = 64'h4444;
        do_req(1, 0, 64'h8000_0058, 0, 0, 0, 0, c);
        check("rr_stall", 64'(c), 64'd3);
        check("rr_data", data_mem, 64'h4444);
        check("rr_n_ar", 64'(n_ar), 64'd1);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_axi_bridge.md
# mem_axi_bridge

Data-side bus interface that sits directly downstream of the pipeline core's EX-stage memory port. It converts the core's level-held load/store request (`mem_rd_en`/`mem_wr_en`, addresses, write data, strobes) into AXI4-Lite master transactions. It returns read data on `data_mem` and holds `stall_mem` high until each request has fully completed on the bus. One transaction is outstanding at a time; there is no buffering beyond the single latched request.

## Interface
Parameters:
- `ADDR_W`, 64, address width (matches core memory address bus)
- `DATA_W`, 64, data width (matches core memory data bus)
- `STRB_W`, `DATA_W/8`, write-strobe width

Ports:
- `clk`  in  1  core clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `mem_rd_en_i`  in  1  core load request, held while `stall_mem_o`=1
- `mem_wr_en_i`  in  1  core store request, held while `stall_mem_o`=1
- `addr_mem_rd_i`  in  ADDR_W  load address
- `addr_mem_wr_i`  in  ADDR_W  store address
- `data_mem_wr_i`  in  DATA_W  store data
- `strb_mem_wr_i`  in  STRB_W  store byte strobes
- `data_mem_o`  out  DATA_W  last captured read data (to core `data_mem_i`)
- `stall_mem_o`  out  1  stall request to core ctrl
- `bus_err_o`  out  1  one-cycle pulse: non-OKAY response on the completed transaction
- `awaddr_o` out ADDR_W; `awvalid_o` out 1; `awready_i` in 1
- `wdata_o` out DATA_W; `wstrb_o` out STRB_W; `wvalid_o` out 1; `wready_i` in 1
- `bresp_i` in 2; `bvalid_i` in 1; `bready_o` out 1
- `araddr_o` out ADDR_W; `arvalid_o` out 1; `arready_i` in 1
- `rdata_i` in DATA_W; `rresp_i` in 2; `rvalid_i` in 1; `rready_o` out 1

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE with `mem_wr_en_i`=1: latch write address, data and strobe. If `mem_rd_en_i` is also 1, latch the read address and set `rd_pend`. Go to WR_REQ with `awvalid_o`=`wvalid_o`=1.
- IDLE with only `mem_rd_en_i`=1: latch the read address. Go to RD_REQ with `arvalid_o`=1.
- WR_REQ: `awvalid_o` drops after the AW handshake and `wvalid_o` drops after the W handshake; the two are independent. Either may complete first, or both in the same cycle. Once both have completed, go to WR_RESP.
- WR_RESP: `bready_o`=1. On `bvalid_i`, go to RD_REQ if `rd_pend`, else go to DONE.
- RD_REQ: `arvalid_o`=1 until `arready_i`, then go to RD_RESP.
- RD_RESP: `rready_o`=1. On `rvalid_i`, capture `rdata_i` into `data_mem_o` and go to DONE.
- DONE: lasts exactly one cycle, then returns to IDLE. A request still present in DONE is treated as the one just served and is not reissued.
- `stall_mem_o` = (`mem_rd_en_i` | `mem_wr_en_i`) & (state ≠ DONE). It is combinational, so the stall is raised in the same cycle the request appears.
- Error handling: a sticky error flag is set if any `bresp_i` or `rresp_i` ≠ 2'b00 during the transaction. `bus_err_o`=flag in DONE. The flag clears on DONE exit. Read data is captured even when the response is an error.
- AXI outputs are registered. Valid signals never drop before their handshake. Address and data outputs are stable while the corresponding valid is high.

## Timing
- Reset values: all valid/ready outputs 0, `data_mem_o`=0, `bus_err_o`=0, address/data/strobe outputs 0, state IDLE. `stall_mem_o` follows its equation.
- Zero-wait slave (readies high, response one cycle after the handshake):
  - Read: IDLE→RD_REQ→RD_RESP→DONE. `stall_mem_o` is high for 3 cycles. `data_mem_o` is valid from the first DONE cycle.
  - Write: IDLE→WR_REQ→WR_RESP→DONE. Stall is 3 cycles.
  - Combined write and read: stall is 5 cycles.
- Each extra slave wait cycle adds exactly one stall cycle.
- `data_mem_o` holds its value until the next read capture; writes do not change it.
- Reset asserted mid-transaction: returns immediately to IDLE, all valids drop, the latched request is discarded. The interconnect is reset together with the bridge.

## Test plan
- Single read of 0x8000_0010 from a zero-wait slave returning 0x1122_3344_5566_7788 -> `araddr_o`=0x8000_0010, stall high for exactly 3 cycles, `data_mem_o`=0x1122_3344_5566_7788 in DONE, `bus_err_o`=0.
- Write of 0xDEAD_BEEF to 0x8000_0008 with strb 0x0F, `awready` delayed 2 cycles and `wready` immediate -> `wvalid_o` drops after 1 cycle, `awvalid_o` holds 3 cycles, one B handshake, stall lasts 5 cycles, `data_mem_o` unchanged.
- Simultaneous `mem_wr_en_i` and `mem_rd_en_i` -> AW/W issued before AR, exactly one transaction of each kind, stall high for 5 cycles with a zero-wait slave, read data captured.
- Read with `rresp`=2'b10 -> `bus_err_o` pulses exactly 1 cycle in DONE, `rdata_i` still captured; the next OKAY read gives `bus_err_o`=0.
- Request held through DONE, then a new read on the next cycle -> the first request produces no duplicate AR; the second produces exactly one AR.
- `rst` pulsed while in RD_RESP -> `arvalid_o`/`rready_o`=0 and `data_mem_o`=0 immediately; a new read after reset completes normally.
